// File: rtl/hs4_sender_pkg.sv
// rtl/hs4_sender_pkg.sv - shared state encoding and sizing helper for the four-phase sender
package hs4_sender_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_REL  = 2'b10,
    ST_ERR  = 2'b11
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/hs4_sender_fifo.sv
// rtl/hs4_sender_fifo.sv - transmit FIFO; head word is presented combinationally on rd_data
module hs_fifo
  import hs4_sender_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              wr_ok, rd_ok;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Full is judged on the registered level, so a pop in the same cycle never admits a write.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/hs4_sender.sv
// rtl/hs4_sender.sv - FIFO-fed four-phase request/acknowledge sender with ack timeout
module hs4_sender
  import hs4_sender_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  full,
  output logic [clog2(DEPTH):0] level,
  output logic                  send,
  output logic [DATA_W-1:0]     data_out,
  input  logic                  ack,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  localparam int CW = clog2(TIMEOUT + 1) + 1;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic [CW-1:0]            cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0]        data_out_q, data_out_d;
  logic                     send_q, send_d;
  logic                     timeout_err_q, timeout_err_d;
  logic                     ack_s, pop, empty, timed_out;
  logic [DATA_W-1:0]        head;

  hs_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign ack_s       = sync_q[SYNC_STAGES-1];
  assign send        = send_q;
  assign data_out    = data_out_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != ST_IDLE);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    data_out_d    = data_out_q;
    timeout_err_d = timeout_err_q;
    pop           = 1'b0;
    sync_d        = {sync_q[SYNC_STAGES-2:0], ack};
    cnt_inc       = cnt_q + CW'(1);
    timed_out     = (TIMEOUT > 0) && (cnt_inc == CW'(TIMEOUT));

    case (state_q)
      ST_IDLE: begin
        // A still-high ack belongs to the previous transfer; hold off until it drops.
        if (!empty && !ack_s) begin
          state_d    = ST_REQ;
          pop        = 1'b1;
          data_out_d = head;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          state_d = ST_REL;
        end else if (timed_out) begin
          state_d       = ST_ERR;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_REL: begin
        if (!ack_s) begin
          state_d = ST_IDLE;
        end else if (timed_out) begin
          state_d       = ST_ERR;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_ERR: begin
        if (err_clr && !ack_s) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // send trails the state by one flop so data_out is settled a full cycle before request rises.
    send_d = (state_q == ST_REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      sync_q        <= '0;
      cnt_q         <= '0;
      data_out_q    <= '0;
      send_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      cnt_q         <= cnt_d;
      data_out_q    <= data_out_d;
      send_q        <= send_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule
